// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared types and helpers for the PRBS sequence checker slice.
//   prbs_state_t : checker FSM states (IDLE, LOCK, CHECK, DONE)
//   ERR_MAX      : saturation value of the mismatch counter
//   lfsr_next()  : one step of the 8-bit Fibonacci LFSR used by the
//                  upstream pattern generator:
//                  next = {cur[6:0], ^(cur & taps)}
// ---------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } prbs_state_t;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur,
                                             input logic [7:0] taps);
        return {cur[6:0], ^(cur & taps)};
    endfunction

endpackage

// File: rtl/prbs_sequence_checker_if.sv
// ---------------------------------------------------------------------------
// prbs_sequence_checker_if
// Groups the stream input and the status outputs of the PRBS checker.
//   start    : 1-cycle pulse, clear counters and begin acquisition
//   en       : data_in carries a valid generator word this cycle
//   data_in  : 8-bit word from the LFSR generator
//   locked   : checker is in CHECK
//   done     : required number of words checked; held until start/reset
//   pass     : meaningful while done; 1 iff no mismatch was counted
//   err_cnt  : saturating mismatch count (CHECK only)
//   sig      : MISR signature (zero unless PRBS_MISR_EN is defined)
// Modports:
//   master : the stimulus/test side (drives start/en/data_in)
//   slave  : the checker itself
// ---------------------------------------------------------------------------
interface prbs_sequence_checker_if;

    logic        start;
    logic        en;
    logic [7:0]  data_in;
    logic        locked;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;
    logic [7:0]  sig;

    modport master (
        output start,
        output en,
        output data_in,
        input  locked,
        input  done,
        input  pass,
        input  err_cnt,
        input  sig
    );

    modport slave (
        input  start,
        input  en,
        input  data_in,
        output locked,
        output done,
        output pass,
        output err_cnt,
        output sig
    );

endinterface

// File: rtl/prbs_ref_lfsr.sv
// ---------------------------------------------------------------------------
// prbs_ref_lfsr
// Reference LFSR holding the word the checker expects to see next.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; expected <= 0
//   load     in   expected <= seed (seed 0 means "no seed loaded")
//   advance  in   expected <= lfsr_next(expected); ignored when load is set
//   seed     in   value loaded by load
//   expected out  current prediction
// ---------------------------------------------------------------------------
module prbs_ref_lfsr
    import prbs_pkg::*;
#(
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] expected
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected <= 8'h00;
        end else if (load) begin
            expected <= seed;
        end else if (advance) begin
            expected <= lfsr_next(expected, TAPS);
        end
    end

endmodule

// File: rtl/prbs_sequence_checker.sv
// ---------------------------------------------------------------------------
// prbs_sequence_checker
// Locks onto the pseudo-random word stream of the 8-bit LFSR generator,
// predicts each next word with a reference LFSR, counts mismatches and
// reports lock, completion and pass/fail.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset (returns to IDLE)
//   bus    slave modport of prbs_sequence_checker_if
//          (start, en, data_in in; locked, done, pass, err_cnt, sig out)
//
// Parameters:
//   TAPS        LFSR feedback mask
//   LOCK_CNT    consecutive correct predictions needed to enter CHECK (>=1)
//   LOSS_THR    consecutive CHECK mismatches that drop lock (>=1)
//   NUM_SAMPLES words checked in CHECK before DONE (1..65535)
//
// Configuration macro:
//   PRBS_MISR_EN  when defined, an 8-bit MISR compacts every CHECK sample
//                 into sig; otherwise no MISR flops exist and sig is 0.
//
// All outputs come straight from flops (state / counters / MISR), so there
// is no combinational path from the inputs to the outputs.
// ---------------------------------------------------------------------------
module prbs_sequence_checker
    import prbs_pkg::*;
#(
    parameter logic [7:0] TAPS        = 8'hB8,
    parameter int         LOCK_CNT    = 4,
    parameter int         LOSS_THR    = 3,
    parameter int         NUM_SAMPLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    prbs_sequence_checker_if.slave  bus
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_THR + 1);

    // Saturating increment of the mismatch counter.
    function automatic logic [15:0] err_sat_inc(input logic [15:0] v);
        return (v == ERR_MAX) ? v : v + 16'd1;
    endfunction

    prbs_state_t          state, state_nxt;
    logic [MATCH_W-1:0]   match_cnt, match_cnt_nxt;
    logic [MISS_W-1:0]    miss_cnt, miss_cnt_nxt;
    logic [15:0]          sample_cnt, sample_cnt_nxt;
    logic [15:0]          err_cnt, err_cnt_nxt;

    logic                 ref_load;
    logic                 ref_advance;
    logic [7:0]           ref_seed;
    logic [7:0]           expected;

    logic                 sample_match;

    assign sample_match = (bus.data_in == expected);

    prbs_ref_lfsr #(
        .TAPS (TAPS)
    ) u_ref_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (ref_load),
        .advance  (ref_advance),
        .seed     (ref_seed),
        .expected (expected)
    );

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_cnt_nxt;
            miss_cnt   <= miss_cnt_nxt;
            sample_cnt <= sample_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, counter and reference-LFSR control
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        match_cnt_nxt  = match_cnt;
        miss_cnt_nxt   = miss_cnt;
        sample_cnt_nxt = sample_cnt;
        err_cnt_nxt    = err_cnt;
        ref_load       = 1'b0;
        ref_advance    = 1'b0;
        ref_seed       = 8'h00;

        if (bus.start) begin
            // start beats any same-cycle sample; loading seed 0 clears the
            // prediction so the next nonzero word reseeds.
            state_nxt      = LOCK;
            match_cnt_nxt  = '0;
            miss_cnt_nxt   = '0;
            sample_cnt_nxt = '0;
            err_cnt_nxt    = '0;
            ref_load       = 1'b1;
            ref_seed       = 8'h00;
        end else if (bus.en) begin
            unique case (state)
                IDLE: begin
                    // Waiting for start; samples carry no meaning yet.
                end

                LOCK: begin
                    // 8'h00 is the LFSR lock-up word and can never seed a
                    // valid sequence, so it is skipped entirely.
                    if (bus.data_in != 8'h00) begin
                        if (expected == 8'h00 || !sample_match) begin
                            ref_load      = 1'b1;
                            ref_seed      = lfsr_next(bus.data_in, TAPS);
                            match_cnt_nxt = '0;
                        end else begin
                            ref_advance = 1'b1;
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state_nxt     = CHECK;
                                match_cnt_nxt = '0;
                                miss_cnt_nxt  = '0;
                            end else begin
                                match_cnt_nxt = match_cnt + 1'b1;
                            end
                        end
                    end
                end

                CHECK: begin
                    // The prediction always steps forward; a corrupted word
                    // never reseeds once locked.
                    ref_advance    = 1'b1;
                    sample_cnt_nxt = sample_cnt + 16'd1;
                    if (sample_match) begin
                        miss_cnt_nxt = '0;
                    end else begin
                        err_cnt_nxt  = err_sat_inc(err_cnt);
                        miss_cnt_nxt = miss_cnt + 1'b1;
                    end

                    // Completion wins over a same-cycle loss of lock.
                    if (sample_cnt == 16'(NUM_SAMPLES - 1)) begin
                        state_nxt = DONE;
                    end else if (!sample_match &&
                                 miss_cnt == MISS_W'(LOSS_THR - 1)) begin
                        // Drop back to acquisition; err_cnt and sample_cnt
                        // carry on across the relock.
                        state_nxt     = LOCK;
                        miss_cnt_nxt  = '0;
                        match_cnt_nxt = '0;
                        ref_load      = 1'b1;
                        ref_seed      = 8'h00;
                    end
                end

                DONE: begin
                    // Results are frozen until the next start.
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.locked  = (state == CHECK);
    assign bus.done    = (state == DONE);
    assign bus.pass    = (state == DONE) && (err_cnt == 16'd0);
    assign bus.err_cnt = err_cnt;

`ifdef PRBS_MISR_EN
    // -----------------------------------------------------------------------
    // MISR: compacts every CHECK sample (including corrupted ones)
    // -----------------------------------------------------------------------
    logic       misr_step;
    logic [7:0] misr_sig;

    assign misr_step = !bus.start && bus.en && (state == CHECK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misr_sig <= 8'h00;
        end else if (bus.start) begin
            misr_sig <= 8'h00;
        end else if (misr_step) begin
            misr_sig <= lfsr_next(misr_sig, TAPS) ^ bus.data_in;
        end
    end

    assign bus.sig = misr_sig;
`else
    assign bus.sig = 8'h00;
`endif

endmodule

// File: tb/tb_prbs_sequence_checker.sv
`timescale 1ns/1ps
module tb_prbs_sequence_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;

    prbs_sequence_checker_if bus();

    prbs_sequence_checker #(
        .TAPS        (8'hB8),
        .LOCK_CNT    (4),
        .LOSS_THR    (3),
        .NUM_SAMPLES (255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    // Next LFSR word computed arithmetically: shift left (mod 256) and add
    // the parity of the tapped bits.
    function automatic int nxt(input int cur);
        int ones;
        int masked;
        ones   = 0;
        masked = cur & 'hB8;
        for (int b = 0; b < 8; b++) ones += (masked >> b) & 1;
        return ((cur * 2) % 256) + (ones % 2);
    endfunction

    // mode: 0 idle, 1 acquiring, 2 checking, 3 finished
    int m_mode = 0;
    int m_exp  = 0;
    int m_run  = 0;
    int m_miss = 0;
    int m_seen = 0;
    int m_err  = 0;
    int m_sig  = 0;
    int m_d    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0;
            m_seen = 0; m_err = 0; m_sig = 0;
        end else if (bus.start) begin
            m_mode = 1; m_exp = 0; m_run = 0; m_miss = 0;
            m_seen = 0; m_err = 0; m_sig = 0;
        end else if (bus.en) begin
            m_d = int'(bus.data_in);
            if (m_mode == 1 && m_d != 0) begin
                if (m_exp != 0 && m_d == m_exp) begin
                    m_run = m_run + 1;
                    m_exp = nxt(m_exp);
                    if (m_run == 4) begin
                        m_mode = 2; m_run = 0; m_miss = 0;
                    end
                end else begin
                    m_exp = nxt(m_d);
                    m_run = 0;
                end
            end else if (m_mode == 2) begin
                m_sig  = nxt(m_sig) ^ m_d;
                m_seen = m_seen + 1;
                if (m_d != m_exp) begin
                    if (m_err < 65535) m_err = m_err + 1;
                    m_miss = m_miss + 1;
                end else begin
                    m_miss = 0;
                end
                m_exp = nxt(m_exp);
                if (m_seen == 255) m_mode = 3;
                else if (m_miss == 3) begin
                    m_mode = 1; m_exp = 0; m_miss = 0; m_run = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("cyc_locked",  32'(bus.locked),  32'(m_mode == 2));
            check("cyc_done",    32'(bus.done),    32'(m_mode == 3));
            check("cyc_pass",    32'(bus.pass),    32'(m_mode == 3 && m_err == 0));
            check("cyc_err_cnt", 32'(bus.err_cnt), 32'(m_err));
`ifdef PRBS_MISR_EN
            check("cyc_sig",     32'(bus.sig),     32'(m_sig));
`else
            check("cyc_sig",     32'(bus.sig),     32'd0);
`endif
        end
    endtask

    // ---------------- stimulus ----------------
    int g = 1;

    task automatic step(input logic s, input logic e, input logic [7:0] d);
        bus.start   = s;
        bus.en      = e;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean();
        step(1'b0, 1'b1, 8'(g));
        g = nxt(g);
    endtask

    task automatic send_bad();
        step(1'b0, 1'b1, 8'(g) ^ 8'h10);
        g = nxt(g);
    endtask

    task automatic start_run();
        step(1'b1, 1'b0, 8'h00);
        g = 1;
    endtask

    task automatic run_until_done(input int limit, output int used);
        used = 0;
        while (bus.done !== 1'b1 && used < limit) begin
            send_clean();
            used++;
        end
        check("done_reached", 32'(bus.done), 32'd1);
    endtask

    int n;

    initial begin
        bus.start   = 1'b0;
        bus.en      = 1'b0;
        bus.data_in = 8'h00;
        fork
            compare_loop();
        join_none

        // model pins
        check("model_nxt_01", 32'(nxt(8'h01)), 32'h02);
        check("model_nxt_80", 32'(nxt(8'h80)), 32'h01);
        check("model_nxt_b8", 32'(nxt(8'hB8)), 32'h70);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h5A);    // sample while IDLE is ignored
        check("rst_locked",  32'(bus.locked),  32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_sig",     32'(bus.sig),     32'd0);

        // 1: clean stream seeded 01
        start_run();
        repeat (4) send_clean();
        check("t1_not_locked_4", 32'(bus.locked), 32'd0);
        send_clean();
        check("t1_locked_5", 32'(bus.locked), 32'd1);
        run_until_done(400, n);
        check("t1_check_words", 32'(n), 32'd255);
        check("t1_pass", 32'(bus.pass), 32'd1);
        check("t1_err",  32'(bus.err_cnt), 32'd0);
        step(1'b0, 1'b1, 8'h33);    // ignored in DONE
        check("t1_done_hold", 32'(bus.done), 32'd1);

        // 2: single corrupted word (stream word 40)
        start_run();
        repeat (39) send_clean();
        send_bad();
        check("t2_err_1",  32'(bus.err_cnt), 32'd1);
        check("t2_locked", 32'(bus.locked),  32'd1);
        run_until_done(400, n);
        check("t2_pass", 32'(bus.pass), 32'd0);
        check("t2_err",  32'(bus.err_cnt), 32'd1);

        // 3: three consecutive corrupted words drop lock, then relock
        start_run();
        repeat (15) send_clean();
        send_bad();
        send_bad();
        check("t3_still_locked", 32'(bus.locked), 32'd1);
        check("t3_err_2", 32'(bus.err_cnt), 32'd2);
        send_bad();
        check("t3_lost", 32'(bus.locked), 32'd0);
        check("t3_err_3", 32'(bus.err_cnt), 32'd3);
        repeat (4) send_clean();
        check("t3_relock_pending", 32'(bus.locked), 32'd0);
        send_clean();
        check("t3_relocked", 32'(bus.locked), 32'd1);
        run_until_done(400, n);
        check("t3_err_kept", 32'(bus.err_cnt), 32'd3);
        check("t3_pass", 32'(bus.pass), 32'd0);

        // 4: leading zero words are ignored
        start_run();
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        repeat (4) send_clean();
        check("t4_not_locked", 32'(bus.locked), 32'd0);
        send_clean();
        check("t4_locked", 32'(bus.locked), 32'd1);

        // 6: async reset mid-CHECK, then clean relock
        repeat (20) send_clean();
        send_bad();
        check("t6_err_before", 32'(bus.err_cnt), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_locked", 32'(bus.locked),  32'd0);
        check("t6_rst_err",    32'(bus.err_cnt), 32'd0);
        check("t6_rst_done",   32'(bus.done),    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_run();
        repeat (5) send_clean();
        check("t6_relocked", 32'(bus.locked), 32'd1);
        run_until_done(400, n);
        check("t6_pass", 32'(bus.pass), 32'd1);

        // 5: en toggling every cycle, garbage on idle cycles
        start_run();
        n = 0;
        while (bus.done !== 1'b1 && n < 600) begin
            send_clean();
            step(1'b0, 1'b0, 8'hAA);
            n++;
        end
        check("t5_done",  32'(bus.done), 32'd1);
        check("t5_pairs", 32'(n), 32'd260);
        check("t5_err",   32'(bus.err_cnt), 32'd0);
        check("t5_pass",  32'(bus.pass), 32'd1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
